limit_arbiter: RTL and testbench

- Time-multiplexes one saturation datapath (clamp x to [min, max]) between NCH requesters, e.g. PI id, PI iq and speed-loop outputs in the FOC chain.
- Holds per-channel min/max limit registers, configured at runtime.
- Round-robin arbitration with valid/ready handshakes on both sides.
- Registered result carries channel tag and saturation flags for anti-windup.

---
 rtl/limit_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_limit_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/limit_arbiter.sv
// Round-robin arbiter sharing one signed clamp datapath across NCH requesters.
// Define LIMIT_ARBITER_SAT_COUNT_EN to add per-channel saturation counters.
module limit_arbiter #(
    parameter int N   = 10,
    parameter int F   = 9,
    parameter int NCH = 3,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [N-1:0]   cfg_max,
    input  logic [N-1:0]   cfg_min,
    output logic           cfg_err,
    input  logic [NCH-1:0] req_valid,
    input  logic [NCH*N-1:0] req_data,
    output logic [NCH-1:0] req_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  out_ch,
    output logic [N-1:0]   out_data,
    output logic           out_sat_hi,
    output logic           out_sat_lo,
    output logic [15:0]    sat_cnt
);

    localparam logic [CW:0] NCH_W = NCH[CW:0];
    localparam logic signed [N-1:0] MAX_DEF = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_DEF = {1'b1, {(N-1){1'b0}}};

    // F is a fixed-point annotation only; it never changes the arithmetic
    if (F >= N || NCH < 2 || NCH > 8) begin : g_bad_param
        $error("limit_arbiter: illegal parameter set");
    end

    logic signed [N-1:0] req_x [NCH];
    logic signed [N-1:0] max_q [NCH];
    logic signed [N-1:0] max_d [NCH];
    logic signed [N-1:0] min_q [NCH];
    logic signed [N-1:0] min_d [NCH];

    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          sat_hi_q, sat_hi_d;
    logic          sat_lo_q, sat_lo_d;
    logic          cfg_err_q, cfg_err_d;
    logic [CW-1:0] rr_q, rr_d;

    logic          slot_free, gnt_found, gnt_vld;
    logic [CW-1:0] gnt_ch;
    logic [CW:0]   idx;
    logic          ch_ok, cfg_ok;
    logic signed [N-1:0] x, lim_hi, lim_lo, clamp_y;
    logic          hi_c, lo_c;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign req_x[k] = $signed(req_data[k*N +: N]);
    end

    assign slot_free = !out_valid_q || out_ready;

    // First asserted request at or after the round-robin pointer, with wrap
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = {1'b0, rr_q} + i[CW:0];
            if (idx >= NCH_W) idx = idx - NCH_W;
            if (!gnt_found && req_valid[idx[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx[CW-1:0];
            end
        end
    end

    assign gnt_vld = slot_free && gnt_found;

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[gnt_ch] = 1'b1;
    end

    // Single shared saturation unit
    always_comb begin
        x       = req_x[gnt_ch];
        lim_hi  = max_q[gnt_ch];
        lim_lo  = min_q[gnt_ch];
        hi_c    = x > lim_hi;
        lo_c    = x < lim_lo;
        clamp_y = x;
        if (hi_c) clamp_y = lim_hi;
        else if (lo_c) clamp_y = lim_lo;
    end

    assign ch_ok  = {1'b0, cfg_ch} < NCH_W;
    assign cfg_ok = cfg_we && ch_ok && ($signed(cfg_min) <= $signed(cfg_max));

    always_comb begin
        max_d       = max_q;
        min_d       = min_q;
        cfg_err_d   = cfg_we && !cfg_ok;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        sat_hi_d    = sat_hi_q;
        sat_lo_d    = sat_lo_q;
        rr_d        = rr_q;
        if (cfg_ok) begin
            max_d[cfg_ch] = $signed(cfg_max);
            min_d[cfg_ch] = $signed(cfg_min);
        end
        if (gnt_vld) begin
            out_valid_d = 1'b1;
            out_ch_d    = gnt_ch;
            out_data_d  = clamp_y;
            sat_hi_d    = hi_c;
            sat_lo_d    = lo_c;
            rr_d        = (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            rr_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                max_q[i] <= MAX_DEF;
                min_q[i] <= MIN_DEF;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            sat_hi_q    <= sat_hi_d;
            sat_lo_q    <= sat_lo_d;
            cfg_err_q   <= cfg_err_d;
            rr_q        <= rr_d;
            max_q       <= max_d;
            min_q       <= min_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign out_sat_hi = sat_hi_q;
    assign out_sat_lo = sat_lo_q;
    assign cfg_err    = cfg_err_q;

`ifdef LIMIT_ARBITER_SAT_COUNT_EN
    logic [15:0] cnt_q [NCH];
    logic [15:0] cnt_d [NCH];

    // A limit rewrite restarts the count, even if the same cycle saturates
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_vld && (hi_c || lo_c) && cnt_q[gnt_ch] != 16'hFFFF)
            cnt_d[gnt_ch] = cnt_q[gnt_ch] + 16'd1;
        if (cfg_ok) cnt_d[cfg_ch] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_cnt = ch_ok ? cnt_q[cfg_ch] : 16'd0;
`else
    assign sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_limit_arbiter.sv
// Directed self-checking bench for limit_arbiter (N=10, NCH=3).
module tb_limit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [9:0]  cfg_max, cfg_min;
    logic        cfg_err;
    logic [2:0]  req_valid;
    logic [29:0] req_data;
    logic [2:0]  req_ready;
    logic        out_valid, out_ready;
    logic [1:0]  out_ch;
    logic [9:0]  out_data;
    logic        out_sat_hi, out_sat_lo;
    logic [15:0] sat_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    limit_arbiter #(.N(10), .F(9), .NCH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_err(cfg_err),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_sat_hi(out_sat_hi), .out_sat_lo(out_sat_lo),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [9:0] v);
        req_data[k*10 +: 10] = v;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ch,
                           input logic [9:0] d, input logic hi, input logic lo);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_flags"}, {30'd0, out_sat_hi, out_sat_lo}, {30'd0, hi, lo});
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0; cfg_min = '0;
        req_valid = '0; req_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_flags", {30'd0, out_sat_hi, out_sat_lo}, 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_sat_cnt", 32'(sat_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Default limits pass the positive extreme untouched
        req_valid = 3'b001; set_req(0, 10'h1FF);
        mid(); chk("def_ready", 32'(req_ready), 32'b001);
        tick(); req_valid = '0;
        chk_out("def", 2'd0, 10'h1FF, 1'b0, 1'b0);

        // ch1 limits [-256, 255]
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_max = 10'd255; cfg_min = 10'h300;
        tick(); cfg_we = 1'b0;
        chk("cfg1_err", 32'(cfg_err), 0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_hold", 32'(out_data), 32'h1FF);

        req_valid = 3'b010; set_req(1, 10'd300);
        mid(); chk("c300_ready", 32'(req_ready), 32'b010);
        tick(); chk_out("c300", 2'd1, 10'd255, 1'b1, 1'b0);
        set_req(1, 10'h2D4);
        tick(); chk_out("cm300", 2'd1, 10'h300, 1'b0, 1'b1);
        set_req(1, 10'd255);
        tick(); chk_out("c255", 2'd1, 10'd255, 1'b0, 1'b0);
        req_valid = '0;

        // Pointer sits at 2 after the ch1 grants
        set_req(0, 10'd10); set_req(1, 10'd20); set_req(2, 10'd30);
        req_valid = 3'b111;
        mid(); chk("rr_g2", 32'(req_ready), 32'b100);
        tick(); chk_out("rr_o2", 2'd2, 10'd30, 1'b0, 1'b0);
        mid(); chk("rr_g0", 32'(req_ready), 32'b001);
        tick(); chk_out("rr_o0", 2'd0, 10'd10, 1'b0, 1'b0);
        mid(); chk("rr_g1", 32'(req_ready), 32'b010);
        tick(); chk_out("rr_o1", 2'd1, 10'd20, 1'b0, 1'b0);
        mid(); chk("rr_g2b", 32'(req_ready), 32'b100);
        tick(); out_ready = 1'b0;

        for (int c = 0; c < 4; c++) begin
            mid(); chk("bp_ready", 32'(req_ready), 0);
            chk_out("bp", 2'd2, 10'd30, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        mid(); chk("bp_rel_ready", 32'(req_ready), 32'b001);
        tick(); req_valid = '0;
        chk_out("bp_rel", 2'd0, 10'd10, 1'b0, 1'b0);

        // Inverted limits on ch2 are rejected
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_max = 10'd5; cfg_min = 10'd10;
        tick(); cfg_we = 1'b0;
        chk("bad_err", 32'(cfg_err), 1);
        tick(); chk("bad_err_end", 32'(cfg_err), 0);
        req_valid = 3'b100; set_req(2, 10'd500);
        tick(); req_valid = '0;
        chk_out("bad_keep", 2'd2, 10'd500, 1'b0, 1'b0);

        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_max = 10'd5; cfg_min = 10'd1;
        tick(); cfg_we = 1'b0;
        chk("badch_err", 32'(cfg_err), 1);

        // New limits on ch0 written in the grant cycle apply one cycle later
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_max = 10'd100; cfg_min = 10'h39C;
        req_valid = 3'b001; set_req(0, 10'd200);
        tick(); cfg_we = 1'b0;
        chk_out("same_old", 2'd0, 10'd200, 1'b0, 1'b0);
        tick(); req_valid = '0;
        chk_out("same_new", 2'd0, 10'd100, 1'b1, 1'b0);

        cfg_ch = 2'd1;
        req_valid = 3'b010; set_req(1, 10'd400);
        tick(); req_valid = '0;
        chk_out("cnt_sat", 2'd1, 10'd255, 1'b1, 1'b0);
`ifdef LIMIT_ARBITER_SAT_COUNT_EN
        chk("cnt_ch1", 32'(sat_cnt), 3);
        cfg_ch = 2'd0; #1;
        chk("cnt_ch0", 32'(sat_cnt), 1);
        cfg_ch = 2'd3; #1;
        chk("cnt_badch", 32'(sat_cnt), 0);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_max = 10'd255; cfg_min = 10'h300;
        tick(); cfg_we = 1'b0;
        chk("cnt_clr", 32'(sat_cnt), 0);
`else
        chk("cnt_off", 32'(sat_cnt), 0);
`endif

        // Asynchronous reset drops an in-flight result at once
        req_valid = 3'b001; set_req(0, 10'd7);
        tick(); req_valid = '0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        tick(); rst_n = 1'b1;
        req_valid = 3'b010; set_req(1, 10'd300);
        tick(); req_valid = '0;
        chk_out("arst_deflim", 2'd1, 10'd300, 1'b0, 1'b0);
        chk("arst_cnt", 32'(sat_cnt), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
